// File: rtl/pc_predict_ras.sv
// Fetch-stage PC register and next-PC predictor with a circular return-address stack.
// Predicts jXX taken and call -> valC. Predicts ret -> RAS top.
// Applies late redirects from M (jXX mispredict) and W (wrong ret target).
module pc_predict_ras #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter bit               USE_RAS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_valid,
  input  logic [3:0]                 f_icode,
  input  logic [WIDTH-1:0]           f_valC,
  input  logic [WIDTH-1:0]           f_valP,
  input  logic                       stall_f,
  input  logic                       m_mispredict,
  input  logic [WIDTH-1:0]           m_valA,
  input  logic                       w_ret_redirect,
  input  logic [WIDTH-1:0]           w_valM,
  output logic [WIDTH-1:0]           f_pc,
  output logic [WIDTH-1:0]           pred_pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;  // next free slot; top of stack is ptr_q - 1
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [WIDTH-1:0] ras_top;
  logic             ras_upd, ras_push, ras_pop;

  assign f_pc      = pc_q;
  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_mem[ptr_q - PTR_ONE];

  // Next-PC prediction from the fetched icode
  always_comb begin
    pred_pc = f_valP;
    if (f_valid) begin
      case (f_icode)
        ICODE_JXX,
        ICODE_CALL: pred_pc = f_valC;
        ICODE_HALT: pred_pc = pc_q;
        ICODE_RET:  pred_pc = (USE_RAS && !ras_empty) ? ras_top : f_valP;
        default:    pred_pc = f_valP;
      endcase
    end
  end

  // A squashed or stalled fetch must leave the RAS untouched
  always_comb begin
    ras_upd  = f_valid && !stall_f && !m_mispredict && !w_ret_redirect && !rst;
    ras_push = ras_upd && USE_RAS && (f_icode == ICODE_CALL);
    ras_pop  = ras_upd && USE_RAS && (f_icode == ICODE_RET) && !ras_empty;
  end

  // RAS pointer and occupancy; a push when full overwrites the oldest entry
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (ras_push) begin
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end else if (ras_pop) begin
      ptr_d = ptr_q - PTR_ONE;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Next PC: M redirect beats W redirect, then stall, then prediction
  always_comb begin
    pc_d = pred_pc;
    if (m_mispredict)        pc_d = m_valA;
    else if (w_ret_redirect) pc_d = w_valM;
    else if (stall_f)        pc_d = pc_q;
  end

  // PC and RAS control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // RAS storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ptr_q] <= f_valP;
  end

endmodule

// File: tb/tb_pc_predict_ras.sv
// Self-checking bench for pc_predict_ras: vector table plus hand-written corner sequences.
module tb_pc_predict_ras;

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic [3:0]  icode;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        stall;
    logic        mis;
    logic [63:0] mva;
    logic        wr;
    logic [63:0] wvm;
    logic        chk_pred;
    logic [63:0] exp_pred;
    logic [63:0] exp_pc;
    int          exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic [3:0]  f_icode = 4'h1;
  logic [63:0] f_valC = '0;
  logic [63:0] f_valP = '0;
  logic        stall_f = 1'b0;
  logic        m_mispredict = 1'b0;
  logic [63:0] m_valA = '0;
  logic        w_ret_redirect = 1'b0;
  logic [63:0] w_valM = '0;
  logic [63:0] f_pc;
  logic [63:0] pred_pc;
  logic [3:0]  ras_count;
  logic        ras_empty;

  int n_chk = 0;
  int n_fail = 0;

  vec_t tbl[$];
  vec_t sb[$];

  pc_predict_ras #(
    .WIDTH    (64),
    .RAS_DEPTH(8),
    .RESET_PC (64'h100),
    .USE_RAS  (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .f_valid       (f_valid),
    .f_icode       (f_icode),
    .f_valC        (f_valC),
    .f_valP        (f_valP),
    .stall_f       (stall_f),
    .m_mispredict  (m_mispredict),
    .m_valA        (m_valA),
    .w_ret_redirect(w_ret_redirect),
    .w_valM        (w_valM),
    .f_pc          (f_pc),
    .pred_pc       (pred_pc),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic valid, logic [3:0] icode,
                              logic [63:0] valc, logic [63:0] valp, logic stall,
                              logic mis, logic [63:0] mva, logic wr, logic [63:0] wvm,
                              logic chk_pred, logic [63:0] exp_pred, logic [63:0] exp_pc,
                              int exp_cnt);
    vec_t v;
    v.name = name; v.rst = r; v.valid = valid; v.icode = icode; v.valc = valc;
    v.valp = valp; v.stall = stall; v.mis = mis; v.mva = mva; v.wr = wr; v.wvm = wvm;
    v.chk_pred = chk_pred; v.exp_pred = exp_pred; v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at negedge, check the combinational prediction, queue the post-edge expectation
  task automatic step(vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; f_valid = v.valid; f_icode = v.icode; f_valC = v.valc; f_valP = v.valp;
    stall_f = v.stall; m_mispredict = v.mis; m_valA = v.mva;
    w_ret_redirect = v.wr; w_valM = v.wvm;
    #1;
    if (v.chk_pred) chk64({v.name, " pred_pc"}, pred_pc, v.exp_pred);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk64({e.name, " f_pc"}, f_pc, e.exp_pc);
    chk64({e.name, " ras_count"}, {60'd0, ras_count}, 64'(e.exp_cnt));
    chk64({e.name, " ras_empty"}, {63'd0, ras_empty}, {63'd0, (e.exp_cnt == 0)});
  endtask

  initial begin
    // Reset held for two cycles
    tbl.push_back(mk("reset1", 1, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h100, 0));
    tbl.push_back(mk("reset2", 1, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h100, 0));
    // jXX predicted taken, then mispredict repair
    tbl.push_back(mk("jxx", 0, 1, 4'h7, 64'h40, 64'h109, 0, 0, 0, 0, 0,
                     1, 64'h40, 64'h40, 0));
    tbl.push_back(mk("mispredict", 0, 1, 4'h1, 0, 64'h42, 0, 1, 64'h10A, 0, 0,
                     1, 64'h42, 64'h10A, 0));
    tbl.push_back(mk("invalid_jxx", 0, 0, 4'h7, 64'hDEAD, 64'h10C, 0, 0, 0, 0, 0,
                     1, 64'h10C, 64'h10C, 0));
    // call then matching ret
    tbl.push_back(mk("call", 0, 1, 4'h8, 64'h200, 64'h109, 0, 0, 0, 0, 0,
                     1, 64'h200, 64'h200, 1));
    tbl.push_back(mk("ret", 0, 1, 4'h9, 0, 64'h201, 0, 0, 0, 0, 0,
                     1, 64'h109, 64'h109, 0));
    // Overfill: 9 calls into 8 entries, then 9 rets
    for (int k = 1; k <= 9; k++) begin
      tbl.push_back(mk($sformatf("fill_call%0d", k), 0, 1, 4'h8, 64'h1000 + 64'(k * 16),
                       64'h500 + 64'(k), 0, 0, 0, 0, 0, 1, 64'h1000 + 64'(k * 16),
                       64'h1000 + 64'(k * 16), (k > 8) ? 8 : k));
    end
    for (int j = 1; j <= 8; j++) begin
      tbl.push_back(mk($sformatf("drain_ret%0d", j), 0, 1, 4'h9, 0, 64'h900 + 64'(j),
                       0, 0, 0, 0, 0, 1, 64'h500 + 64'(10 - j), 64'h500 + 64'(10 - j),
                       8 - j));
    end
    tbl.push_back(mk("empty_ret", 0, 1, 4'h9, 0, 64'h999, 0, 0, 0, 0, 0,
                     1, 64'h999, 64'h999, 0));
    // Squashed call under stall+mispredict, then stall holds PC and RAS
    tbl.push_back(mk("call_pre", 0, 1, 4'h8, 64'h600, 64'h109, 0, 0, 0, 0, 0,
                     1, 64'h600, 64'h600, 1));
    tbl.push_back(mk("squash_call", 0, 1, 4'h8, 64'h700, 64'h608, 1, 1, 64'h55, 0, 0,
                     1, 64'h700, 64'h55, 1));
    for (int s = 1; s <= 3; s++) begin
      tbl.push_back(mk($sformatf("stall%0d", s), 0, 1, 4'h8, 64'h777, 64'h5E, 1, 0, 0,
                       0, 0, 1, 64'h777, 64'h55, 1));
    end
    // ret predicted from RAS, then W redirect; redirect also squashes a call push
    tbl.push_back(mk("ret_pred", 0, 1, 4'h9, 0, 64'h56, 0, 0, 0, 0, 0,
                     1, 64'h109, 64'h109, 0));
    tbl.push_back(mk("ret_redirect", 0, 1, 4'h1, 0, 64'h10A, 0, 0, 0, 1, 64'h300,
                     1, 64'h10A, 64'h300, 0));
    tbl.push_back(mk("redir_call", 0, 1, 4'h8, 64'h800, 64'h305, 0, 0, 0, 1, 64'h20,
                     1, 64'h800, 64'h20, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Halt self-loops until a redirect
    for (int h = 1; h <= 3; h++) begin
      step(mk($sformatf("halt%0d", h), 0, 1, 4'h0, 0, 64'h21, 0, 0, 0, 0, 0,
              1, 64'h20, 64'h20, 0));
    end
    // Both redirects together: M wins
    step(mk("both_redirect", 0, 1, 4'h0, 0, 64'h21, 0, 1, 64'h60, 1, 64'h70,
            1, 64'h20, 64'h60, 0));
    step(mk("call_b4_rst", 0, 1, 4'h8, 64'h80, 64'h65, 0, 0, 0, 0, 0,
            1, 64'h80, 64'h80, 1));
    // Reset overrides stall, redirects and a pending push
    step(mk("rst_mid", 1, 1, 4'h8, 64'h90, 64'h85, 1, 1, 64'h77, 1, 64'h78,
            1, 64'h90, 64'h100, 0));
    step(mk("ret_after_rst", 0, 1, 4'h9, 0, 64'h102, 0, 0, 0, 0, 0,
            1, 64'h102, 64'h102, 0));
    // Halt then reset returns to RESET_PC
    step(mk("halt_pre_rst", 0, 1, 4'h0, 0, 64'h103, 0, 0, 0, 0, 0,
            1, 64'h102, 64'h102, 0));
    step(mk("halt_rst", 1, 1, 4'h0, 0, 64'h103, 0, 0, 0, 0, 0,
            1, 64'h102, 64'h100, 0));

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
